// File: rtl/cci_mpf_shim_lockstep_issue.sv
// Lockstep issue shim: dequeues a two-channel head entry only when every
// channel it carries can accept a request, registers the issued requests
// for one cycle and tracks outstanding requests per channel.
module cci_mpf_shim_lockstep_issue #(
  parameter int C0TX_BITS       = 128,
  parameter int C1TX_BITS       = 640,
  parameter int MAX_C0_INFLIGHT = 64,
  parameter int MAX_C1_INFLIGHT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 head_not_empty,
  input  logic                 head_c0_valid,
  input  logic [C0TX_BITS-1:0] head_c0_data,
  input  logic                 head_c1_valid,
  input  logic [C1TX_BITS-1:0] head_c1_data,
  output logic                 deqTx,
  input  logic                 c0_alm_full,
  input  logic                 c1_alm_full,
  input  logic                 c0_rsp,
  input  logic                 c1_rsp,
  output logic                 out_c0_valid,
  output logic [C0TX_BITS-1:0] out_c0_data,
  output logic                 out_c1_valid,
  output logic [C1TX_BITS-1:0] out_c1_data,
  output logic [7:0]           c0_inflight,
  output logic [7:0]           c1_inflight,
  output logic                 rsp_underflow
);

  localparam logic [7:0] L_MAX_C0 = 8'(MAX_C0_INFLIGHT);
  localparam logic [7:0] L_MAX_C1 = 8'(MAX_C1_INFLIGHT);

  // Per-channel view so both counters share one generated implementation.
  logic [7:0] r_cnt [2];
  logic [7:0] w_max [2];
  logic [1:0] w_ok;
  logic [1:0] w_head_valid;
  logic [1:0] w_issue;
  logic [1:0] w_rsp;
  logic [1:0] w_uf_evt;
  logic       w_fire;

  logic                 r_out_c0_valid;
  logic [C0TX_BITS-1:0] r_out_c0_data;
  logic                 r_out_c1_valid;
  logic [C1TX_BITS-1:0] r_out_c1_data;
  logic                 r_underflow;

  assign w_max[0]     = L_MAX_C0;
  assign w_max[1]     = L_MAX_C1;
  assign w_head_valid = {head_c1_valid, head_c0_valid};
  assign w_rsp        = {c1_rsp, c0_rsp};

  // Admission uses the registered count, so a same-cycle response never
  // opens a slot early.
  assign w_ok[0] = !c0_alm_full && (r_cnt[0] < w_max[0]);
  assign w_ok[1] = !c1_alm_full && (r_cnt[1] < w_max[1]);

  // The whole head entry goes or nothing goes; reset blocks any dequeue.
  assign w_fire = !reset && head_not_empty &&
                  (!head_c0_valid || w_ok[0]) &&
                  (!head_c1_valid || w_ok[1]);
  assign deqTx  = w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign w_issue[gi]  = w_fire && w_head_valid[gi];
      // A response against an empty counter is an error unless an issue
      // lands in the same cycle and cancels it out.
      assign w_uf_evt[gi] = w_rsp[gi] && !w_issue[gi] && (r_cnt[gi] == 8'd0);

      // Outstanding-request counter: +1 on issue, -1 on response, never below 0.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt[gi] <= 8'd0;
        end else if (w_issue[gi] && !w_rsp[gi]) begin
          r_cnt[gi] <= r_cnt[gi] + 8'd1;
        end else if (w_rsp[gi] && !w_issue[gi] && (r_cnt[gi] != 8'd0)) begin
          r_cnt[gi] <= r_cnt[gi] - 8'd1;
        end
      end
    end
  endgenerate

  // Register the issued entry; valids drop on any cycle without a fire,
  // payloads hold until the next fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_c0_valid <= 1'b0;
      r_out_c1_valid <= 1'b0;
      r_out_c0_data  <= '0;
      r_out_c1_data  <= '0;
    end else begin
      r_out_c0_valid <= w_issue[0];
      r_out_c1_valid <= w_issue[1];
      if (w_fire) begin
        r_out_c0_data <= head_c0_data;
        r_out_c1_data <= head_c1_data;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (|w_uf_evt) begin
      r_underflow <= 1'b1;
    end
  end

  assign out_c0_valid  = r_out_c0_valid;
  assign out_c0_data   = r_out_c0_data;
  assign out_c1_valid  = r_out_c1_valid;
  assign out_c1_data   = r_out_c1_data;
  assign c0_inflight   = r_cnt[0];
  assign c1_inflight   = r_cnt[1];
  assign rsp_underflow = r_underflow;

endmodule

// File: tb/tb_cci_mpf_shim_lockstep_issue.sv
// Bench for the lockstep issue shim: directed scenarios followed by random
// traffic, with a queue-based scoreboard for the registered outputs.
module tb_cci_mpf_shim_lockstep_issue;

  localparam int C0B  = 64;
  localparam int C1B  = 96;
  localparam int MAX0 = 4;
  localparam int MAX1 = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           head_not_empty = 1'b0;
  logic           head_c0_valid = 1'b0;
  logic [C0B-1:0] head_c0_data = '0;
  logic           head_c1_valid = 1'b0;
  logic [C1B-1:0] head_c1_data = '0;
  logic           deqTx;
  logic           c0_alm_full = 1'b0;
  logic           c1_alm_full = 1'b0;
  logic           c0_rsp = 1'b0;
  logic           c1_rsp = 1'b0;
  logic           out_c0_valid;
  logic [C0B-1:0] out_c0_data;
  logic           out_c1_valid;
  logic [C1B-1:0] out_c1_data;
  logic [7:0]     c0_inflight;
  logic [7:0]     c1_inflight;
  logic           rsp_underflow;

  cci_mpf_shim_lockstep_issue #(
    .C0TX_BITS(C0B), .C1TX_BITS(C1B),
    .MAX_C0_INFLIGHT(MAX0), .MAX_C1_INFLIGHT(MAX1)
  ) dut (
    .clk(clk), .reset(reset),
    .head_not_empty(head_not_empty),
    .head_c0_valid(head_c0_valid), .head_c0_data(head_c0_data),
    .head_c1_valid(head_c1_valid), .head_c1_data(head_c1_data),
    .deqTx(deqTx),
    .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
    .c0_rsp(c0_rsp), .c1_rsp(c1_rsp),
    .out_c0_valid(out_c0_valid), .out_c0_data(out_c0_data),
    .out_c1_valid(out_c1_valid), .out_c1_data(out_c1_data),
    .c0_inflight(c0_inflight), .c1_inflight(c1_inflight),
    .rsp_underflow(rsp_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             cyc;
    logic           v0;
    logic [C0B-1:0] d0;
    logic           v1;
    logic [C1B-1:0] d1;
  } exp_t;
  exp_t q[$];

  // Reference model state: plain integers.
  int             m_cnt0 = 0;
  int             m_cnt1 = 0;
  bit             m_uf   = 1'b0;
  logic [C0B-1:0] m_d0   = '0;
  logic [C1B-1:0] m_d1   = '0;

  // Monitor: every presented output must be the next expected entry, in the
  // cycle it was due; an overdue entry is reported as missing.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missing_output cyc=%0d due=%0d got=none", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (out_c0_valid === 1'b1 || out_c1_valid === 1'b1) begin
      total++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d got v0=%b v1=%b want none", cyc, out_c0_valid, out_c1_valid);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_c0_valid !== e.v0 || out_c1_valid !== e.v1 ||
            (e.v0 && out_c0_data !== e.d0) || (e.v1 && out_c1_data !== e.d1)) begin
          bad++;
          $display("FAIL output cyc=%0d got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                   cyc, out_c0_valid, out_c0_data, out_c1_valid, out_c1_data, e.v0, e.d0, e.v1, e.d1);
        end
      end
    end
  end

  // One cycle of stimulus; want = -1 means no directed expectation on deqTx.
  task automatic step(input bit rst, hne, v0, v1, af0, af1, r0, r1, input int want);
    bit mf, is0, is1;
    int n0, n1;
    bit nuf;
    logic [C0B-1:0] nd0;
    logic [C1B-1:0] nd1;
    reset = rst; head_not_empty = hne;
    head_c0_valid = v0; head_c1_valid = v1;
    c0_alm_full = af0; c1_alm_full = af1;
    c0_rsp = r0; c1_rsp = r1;
    head_c0_data = {$urandom, $urandom};
    head_c1_data = {$urandom, $urandom, $urandom};
    #1;
    mf = !rst && hne && (!v0 || (!af0 && m_cnt0 < MAX0)) && (!v1 || (!af1 && m_cnt1 < MAX1));
    total++;
    if (deqTx !== mf) begin
      bad++;
      $display("FAIL deqTx cyc=%0d got=%b want=%b", cyc, deqTx, mf);
    end
    if (want >= 0) begin
      total++;
      if (deqTx !== want[0]) begin
        bad++;
        $display("FAIL deqTx_directed cyc=%0d got=%b want=%b", cyc, deqTx, want[0]);
      end
    end
    if (mf && (v0 || v1)) q.push_back('{cyc + 1, v0, head_c0_data, v1, head_c1_data});
    is0 = mf && v0;
    is1 = mf && v1;
    n0 = m_cnt0; n1 = m_cnt1; nuf = m_uf; nd0 = m_d0; nd1 = m_d1;
    if (rst) begin
      n0 = 0; n1 = 0; nuf = 0; nd0 = '0; nd1 = '0;
    end else begin
      if (mf) begin nd0 = head_c0_data; nd1 = head_c1_data; end
      n0 = n0 + int'(is0) - int'(r0);
      if (n0 < 0) begin n0 = 0; nuf = 1; end
      n1 = n1 + int'(is1) - int'(r1);
      if (n1 < 0) begin n1 = 0; nuf = 1; end
    end
    @(posedge clk); #1;
    m_cnt0 = n0; m_cnt1 = n1; m_uf = nuf; m_d0 = nd0; m_d1 = nd1;
    total++;
    if (c0_inflight !== 8'(m_cnt0)) begin
      bad++; $display("FAIL c0_inflight cyc=%0d got=%0d want=%0d", cyc, c0_inflight, m_cnt0);
    end
    total++;
    if (c1_inflight !== 8'(m_cnt1)) begin
      bad++; $display("FAIL c1_inflight cyc=%0d got=%0d want=%0d", cyc, c1_inflight, m_cnt1);
    end
    total++;
    if (rsp_underflow !== m_uf) begin
      bad++; $display("FAIL rsp_underflow cyc=%0d got=%b want=%b", cyc, rsp_underflow, m_uf);
    end
    total++;
    if (out_c0_data !== m_d0 || out_c1_data !== m_d1) begin
      bad++; $display("FAIL out_data cyc=%0d got=%h/%h want=%h/%h", cyc, out_c0_data, out_c1_data, m_d0, m_d1);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset, with a head present: no dequeue allowed.
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    // c0-only head fires immediately.
    step(0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Both valid with c1 almost full stalls, then both issue together.
    step(0, 1, 1, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    // Empty head entry is dequeued with no output.
    step(0, 1, 0, 0, 1, 1, 0, 0, 1);
    // Fill channel 0 to its limit, then the boundary behaviour at count == MAX.
    for (int i = 0; i < MAX0; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < MAX0; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Response against an empty c1 counter sets a sticky error.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Response at count 0 with a same-cycle issue: no error.
    step(0, 1, 0, 1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // c1-only stream keeps flowing while c0 is almost full.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 1, 0, 0, (i >= 4), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset while an output is valid and c0 holds 3 outstanding.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), -1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_lockstep_issue.md
CCI_MPF_SHIM_LOCKSTEP_ISSUE -- requirements
Module: cci_mpf_shim_lockstep_issue

Interface
REQ-001 Parameter: C0TX_BITS, default 128, width of the channel 0 request payload (valid bits excluded).
REQ-002 Parameter: C1TX_BITS, default 640, width of the channel 1 request payload (valid bits excluded).
REQ-003 Parameter: MAX_C0_INFLIGHT, default 64, maximum outstanding channel 0 requests; legal range 1..255.
REQ-004 Parameter: MAX_C1_INFLIGHT, default 64, maximum outstanding channel 1 requests; legal range 1..255.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: head_not_empty  in  1  the lockstep buffer head holds an entry.
REQ-008 Port: head_c0_valid  in  1  channel 0 request present in the head entry.
REQ-009 Port: head_c0_data  in  C0TX_BITS  channel 0 request payload.
REQ-010 Port: head_c1_valid  in  1  channel 1 request present in the head entry.
REQ-011 Port: head_c1_data  in  C1TX_BITS  channel 1 request payload.
REQ-012 Port: deqTx  out  1  dequeues the lockstep buffer head (both channels together).
REQ-013 Port: c0_alm_full / c1_alm_full  in  1 each  downstream TX almost-full per channel.
REQ-014 Port: c0_rsp / c1_rsp  in  1 each  one response returned on the channel this cycle.
REQ-015 Port: out_c0_valid / out_c0_data  out  1 / C0TX_BITS  registered channel 0 request.
REQ-016 Port: out_c1_valid / out_c1_data  out  1 / C1TX_BITS  registered channel 1 request.
REQ-017 Port: c0_inflight / c1_inflight  out  8 each  current outstanding request counts.
REQ-018 Port: rsp_underflow  out  1  sticky error: a response arrived with the matching count at 0.

Function
REQ-019 ch0_ok SHALL be (!c0_alm_full && c0_inflight < MAX_C0_INFLIGHT); ch1_ok SHALL be defined the same way on channel 1.
REQ-020 fire SHALL be head_not_empty && (!head_c0_valid || ch0_ok) && (!head_c1_valid || ch1_ok).
REQ-021 deqTx SHALL equal fire, combinationally, in the same cycle.
REQ-022 Both channels SHALL issue together or not at all; a head entry is never split across cycles.
REQ-023 A fired head entry with both valids 0 SHALL be dequeued with no output valid.
REQ-024 On the clock edge after fire, out_c0_valid SHALL be head_c0_valid and out_c1_valid SHALL be head_c1_valid, with out_*_data registered from head_*_data: latency exactly 1 cycle.
REQ-025 In any cycle without fire, both out valids SHALL be 0 on the next edge; out_*_data SHALL hold its previous value.
REQ-026 Each counter SHALL increment by 1 on an issue for its channel, decrement by 1 on a response for its channel, and stay unchanged when both happen in the same cycle.
REQ-027 The admission decision SHALL use the registered count, so an issue and a response in the same cycle at count == MAX still stalls that cycle.
REQ-028 A response with count 0 and no same-cycle issue SHALL hold the count at 0 and set rsp_underflow, which stays 1 until reset.
REQ-029 A response with count 0 and a same-cycle issue SHALL leave the count at 0 and SHALL NOT set rsp_underflow.
REQ-030 Counts SHALL never exceed MAX_Cx_INFLIGHT; counter arithmetic is 8-bit unsigned.
REQ-031 Almost-full on one channel SHALL NOT stall heads whose only request is on the other channel.

Reset
REQ-032 While reset is high, deqTx SHALL be 0 regardless of the inputs.
REQ-033 On the edge where reset is high: out valids, both counters and rsp_underflow SHALL become 0; out_*_data SHALL become 0.
REQ-034 Reset asserted mid-stream SHALL discard any registered output, with no output valid on the first cycle after reset deasserts.

Verification
REQ-035 Head c0-only, alm_full low, count 0 -> deqTx=1 same cycle, out_c0_valid=1 next cycle, c0_inflight=1.
REQ-036 Head with both valid, c1_alm_full=1 -> deqTx=0, no outputs; drop c1_alm_full -> both outputs valid on the same cycle.
REQ-037 MAX_C0_INFLIGHT=4, issue 4 reads with no responses -> 5th head stalls; c0_rsp and an issue in the same cycle at count 4 -> still stalled; the next cycle (count 3) -> fires.
REQ-038 c1_rsp pulse with c1_inflight=0 -> count stays 0, rsp_underflow=1 and stays 1 until reset.
REQ-039 Continuous c1-only heads with c0_alm_full=1 -> one deq every cycle, c1 output stream back-to-back.
REQ-040 Reset pulsed while out_c0_valid=1 and c0_inflight=3 -> next cycle all outputs 0, counts 0, deqTx=0 during reset.
